// File: rtl/prom_seq_pkg.sv
// Shared types and constants for the 6301-footprint PROM access sequencer.
package prom_seq_pkg;

    localparam int unsigned ROM_AW = 8;
    localparam int unsigned ROM_DW = 4;

    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_STABLE_CYCLES = 2;
    localparam int unsigned DEF_ACCESS_CYCLES = 4;
    localparam int unsigned DEF_HOLD_CYCLES   = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        FETCH,
        DRIVE,
        HOLD
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bus_sync.sv
// N-bit multi-flop synchronizer with a synchronous reset value.
module bus_sync #(
    parameter int unsigned       WIDTH   = 1,
    parameter int unsigned       STAGES  = 2,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                r_chain[i] <= RST_VAL;
            end
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < int'(STAGES); i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/prom_access_sequencer.sv
// Clocked front end for the 256x4 PROM replacement: synchronize pins, wait for a
// settled address, fetch from the ROM array and drive the output buffer with hold guard.
module prom_access_sequencer
    import prom_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned ACCESS_CYCLES = DEF_ACCESS_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROM_AW-1:0] addr,
    input  logic              ce1_n,
    input  logic              ce2_n,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [ROM_DW-1:0] rom_data,
    output logic [ROM_DW-1:0] data,
    output logic              oe
);

    localparam int unsigned CW = $clog2(max3(STABLE_CYCLES, ACCESS_CYCLES, HOLD_CYCLES)) + 1;

    logic [ROM_AW-1:0] w_addr_s;
    logic [1:0]        w_ce_s;
    logic              w_sel_s;
    logic              w_match;

    state_e            r_state,    w_state_nxt;
    logic [ROM_AW-1:0] r_cap_addr, w_cap_nxt;
    logic [CW-1:0]     r_cnt,      w_cnt_nxt;
    logic [CW-1:0]     r_hcnt,     w_hcnt_nxt;
    logic [ROM_AW-1:0] r_rom_addr, w_rom_addr_nxt;
    logic              r_rom_rd,   w_rom_rd_nxt;
    logic              r_oe,       w_oe_nxt;
    logic              r_rd_d;
    logic [ROM_DW-1:0] r_data;

    bus_sync #(.WIDTH(ROM_AW), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_addr_sync (
        .clk (clk),
        .rst (rst),
        .i_d (addr),
        .o_q (w_addr_s)
    );

    // Enables reset to "deselected".
    bus_sync #(.WIDTH(2), .STAGES(SYNC_STAGES), .RST_VAL(2'b11)) u_ce_sync (
        .clk (clk),
        .rst (rst),
        .i_d ({ce2_n, ce1_n}),
        .o_q (w_ce_s)
    );

    assign w_sel_s = ~w_ce_s[0] & ~w_ce_s[1];
    assign w_match = (w_addr_s == r_cap_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cap_nxt      = r_cap_addr;
        w_cnt_nxt      = r_cnt;
        w_hcnt_nxt     = r_hcnt;
        w_rom_addr_nxt = r_rom_addr;
        w_rom_rd_nxt   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_sel_s) begin
                    w_cap_nxt   = w_addr_s;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (!w_sel_s) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (!w_match) begin
                    w_cap_nxt = w_addr_s;
                    w_cnt_nxt = '0;
                end else if (r_cnt >= CW'(STABLE_CYCLES - 1)) begin
                    w_cnt_nxt      = '0;
                    w_rom_addr_nxt = r_cap_addr;
                    w_rom_rd_nxt   = 1'b1;
                    w_state_nxt    = FETCH;
                end else begin
                    w_cnt_nxt = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);
                end
            end
            FETCH: begin
                if (r_cnt >= CW'(ACCESS_CYCLES - 1)) begin
                    w_cnt_nxt = '0;
                    if (!w_sel_s) begin
                        w_state_nxt = IDLE;
                    end else if (!w_match) begin
                        w_cap_nxt   = w_addr_s;
                        w_state_nxt = SETTLE;
                    end else begin
                        w_state_nxt = DRIVE;
                    end
                end else begin
                    w_cnt_nxt = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);
                end
            end
            DRIVE: begin
                if (!w_sel_s || !w_match) begin
                    w_hcnt_nxt  = '0;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                // Pins are ignored until the guard interval has fully elapsed.
                if (r_hcnt >= CW'(HOLD_CYCLES - 1)) begin
                    w_hcnt_nxt = '0;
                    if (w_sel_s) begin
                        w_cap_nxt   = w_addr_s;
                        w_cnt_nxt   = '0;
                        w_state_nxt = SETTLE;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_hcnt_nxt = (r_hcnt == {CW{1'b1}}) ? r_hcnt : r_hcnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_oe_nxt = (w_state_nxt == DRIVE) || (w_state_nxt == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_addr <= '0;
            r_cnt      <= '0;
            r_hcnt     <= '0;
            r_rom_addr <= '0;
            r_rom_rd   <= 1'b0;
            r_rd_d     <= 1'b0;
            r_oe       <= 1'b0;
            r_data     <= '0;
        end else begin
            r_cap_addr <= w_cap_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hcnt     <= w_hcnt_nxt;
            r_rom_addr <= w_rom_addr_nxt;
            r_rom_rd   <= w_rom_rd_nxt;
            r_rd_d     <= r_rom_rd;
            r_oe       <= w_oe_nxt;
            // ROM data is valid the cycle after the strobe, always inside FETCH.
            if (r_rd_d) begin
                r_data <= rom_data;
            end
        end
    end

    assign rom_addr = r_rom_addr;
    assign rom_rd   = r_rom_rd;
    assign data     = r_data;
    assign oe       = r_oe;

endmodule

// File: tb/tb_prom_access_sequencer.sv
// Scenario bench for prom_access_sequencer with a synchronous ROM model and a
// scoreboard of expected fetch addresses and driven nibbles.
module tb_prom_access_sequencer;
    import prom_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] addr = 8'h00;
    logic       ce1_n = 1'b1;
    logic       ce2_n = 1'b1;
    logic [7:0] rom_addr;
    logic       rom_rd;
    logic [3:0] rom_data = 4'h0;
    logic [3:0] data;
    logic       oe;

    int errors = 0;
    int checks = 0;
    int n_rd   = 0;
    logic prev_oe = 1'b0;

    logic [7:0] exp_rd_q[$];
    logic [3:0] exp_drv_q[$];

    prom_access_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .ce1_n    (ce1_n),
        .ce2_n    (ce2_n),
        .rom_addr (rom_addr),
        .rom_rd   (rom_rd),
        .rom_data (rom_data),
        .data     (data),
        .oe       (oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) rom_data <= 4'h0;
        else if (rom_rd) rom_data <= rom_addr[3:0] ^ 4'hA;
    end

    // Scoreboard: every strobe and every oe rising edge must match a queued expectation.
    always @(negedge clk) begin
        if (rom_rd === 1'b1) begin
            logic [7:0] ea;
            n_rd++;
            checks++;
            if (exp_rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: rom_addr=%h with no fetch expected", rom_addr);
            end else begin
                ea = exp_rd_q.pop_front();
                if (rom_addr !== ea) begin
                    errors++;
                    $display("FAIL rd_addr: got %h expected %h", rom_addr, ea);
                end
            end
        end
        if (oe === 1'b1 && prev_oe !== 1'b1) begin
            logic [3:0] ed;
            checks++;
            if (exp_drv_q.size() == 0) begin
                errors++;
                $display("FAIL oe_unexpected: data=%h with no drive expected", data);
            end else begin
                ed = exp_drv_q.pop_front();
                if (data !== ed) begin
                    errors++;
                    $display("FAIL drv_data: got %h expected %h", data, ed);
                end
            end
        end
        prev_oe = oe;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_oe(input logic val, input int max_edges, output int edges);
        edges = 0;
        do begin
            step();
            edges++;
        end while (oe !== val && edges < max_edges);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (oe !== 1'b0 || data !== 4'h0) begin
            errors++;
            $display("FAIL reset_out: oe=%b data=%h expected oe=0 data=0", oe, data);
        end
        checks++;
        if (rom_rd !== 1'b0 || rom_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_rom: rom_rd=%b rom_addr=%h expected 0/00", rom_rd, rom_addr);
        end
        checks++;
        if (dut.r_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected IDLE", dut.r_state);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_read();
        int n;
        int rd0;
        rd0   = n_rd;
        addr  = 8'h35;
        ce1_n = 1'b0;
        ce2_n = 1'b0;
        exp_rd_q.push_back(8'h35);
        exp_drv_q.push_back(4'hF);
        wait_oe(1'b1, 20, n);
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL basic_latency: oe rose after %0d edges expected 9", n);
        end
        repeat (3) step();
        checks++;
        if (oe !== 1'b1 || data !== 4'hF) begin
            errors++;
            $display("FAIL basic_drive: oe=%b data=%h expected 1/f", oe, data);
        end
        checks++;
        if (n_rd - rd0 != 1) begin
            errors++;
            $display("FAIL basic_rd_count: got %0d strobes expected 1", n_rd - rd0);
        end
    endtask

    task automatic test_deselect_hold();
        ce2_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (oe !== 1'b1 || data !== 4'hF) begin
                errors++;
                $display("FAIL hold_edge%0d: oe=%b data=%h expected 1/f", i, oe, data);
            end
        end
        step();
        checks++;
        if (oe !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: oe=%b expected 0 on edge 5", oe);
        end
        checks++;
        if (dut.r_state !== IDLE) begin
            errors++;
            $display("FAIL hold_state: got %0d expected IDLE", dut.r_state);
        end
    endtask

    task automatic test_glitch();
        int n;
        int rd0;
        rd0   = n_rd;
        addr  = 8'h10;
        ce1_n = 1'b0;
        ce2_n = 1'b0;
        exp_rd_q.push_back(8'h10);
        exp_drv_q.push_back(4'hA);
        step();
        addr = 8'h11;
        step();
        addr = 8'h10;
        wait_oe(1'b1, 20, n);
        checks++;
        if (n + 2 != 11) begin
            errors++;
            $display("FAIL glitch_latency: oe rose after %0d edges expected 11", n + 2);
        end
        checks++;
        if (n_rd - rd0 != 1) begin
            errors++;
            $display("FAIL glitch_rd_count: got %0d strobes expected 1", n_rd - rd0);
        end
    endtask

    task automatic test_addr_change();
        int n;
        addr = 8'h20;
        exp_rd_q.push_back(8'h20);
        exp_drv_q.push_back(4'hA);
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (oe !== 1'b1 || data !== 4'hA) begin
                errors++;
                $display("FAIL chg_hold_edge%0d: oe=%b data=%h expected 1/a", i, oe, data);
            end
        end
        step();
        checks++;
        if (oe !== 1'b0) begin
            errors++;
            $display("FAIL chg_release: oe=%b expected 0 on edge 5", oe);
        end
        wait_oe(1'b1, 20, n);
        checks++;
        if (n + 5 != 11) begin
            errors++;
            $display("FAIL chg_latency: oe returned after %0d edges expected 11", n + 5);
        end
        checks++;
        if (data !== 4'hA) begin
            errors++;
            $display("FAIL chg_data: got %h expected a", data);
        end
    endtask

    task automatic test_deselect_fetch();
        int  n;
        logic seen_oe;
        ce1_n = 1'b1;
        repeat (8) step();
        checks++;
        if (oe !== 1'b0 || dut.r_state !== IDLE) begin
            errors++;
            $display("FAIL dsf_idle: oe=%b state=%0d expected 0/IDLE", oe, dut.r_state);
        end
        addr  = 8'h42;
        ce1_n = 1'b0;
        exp_rd_q.push_back(8'h42);
        n = 0;
        do begin
            step();
            n++;
        end while (rom_rd !== 1'b1 && n < 12);
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL dsf_rd_latency: rom_rd after %0d edges expected 5", n);
        end
        step();
        ce1_n   = 1'b1;
        seen_oe = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (oe !== 1'b0) seen_oe = 1'b1;
        end
        checks++;
        if (seen_oe !== 1'b0) begin
            errors++;
            $display("FAIL dsf_oe: oe asserted=%b expected never", seen_oe);
        end
        checks++;
        if (dut.r_state !== IDLE) begin
            errors++;
            $display("FAIL dsf_state: got %0d expected IDLE", dut.r_state);
        end
    endtask

    task automatic test_reset_drive();
        int n;
        addr  = 8'h7C;
        ce1_n = 1'b0;
        ce2_n = 1'b0;
        exp_rd_q.push_back(8'h7C);
        exp_drv_q.push_back(4'h6);
        wait_oe(1'b1, 20, n);
        checks++;
        if (n != 9 || data !== 4'h6) begin
            errors++;
            $display("FAIL rstd_setup: edges=%0d data=%h expected 9/6", n, data);
        end
        rst = 1'b1;
        step();
        checks++;
        if (oe !== 1'b0 || data !== 4'h0 || rom_rd !== 1'b0) begin
            errors++;
            $display("FAIL rstd_clear: oe=%b data=%h rom_rd=%b expected 0/0/0", oe, data, rom_rd);
        end
        rst = 1'b0;
        exp_rd_q.push_back(8'h7C);
        exp_drv_q.push_back(4'h6);
        wait_oe(1'b1, 20, n);
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL rstd_latency: oe rose after %0d edges expected 9", n);
        end
    endtask

    task automatic test_drain();
        repeat (3) step();
        checks++;
        if (exp_rd_q.size() != 0) begin
            errors++;
            $display("FAIL drain_rd: %0d fetches expected but not seen", exp_rd_q.size());
        end
        checks++;
        if (exp_drv_q.size() != 0) begin
            errors++;
            $display("FAIL drain_drv: %0d drives expected but not seen", exp_drv_q.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_read();
        test_deselect_hold();
        test_glitch();
        test_addr_change();
        test_deselect_fetch();
        test_reset_drive();
        test_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
